// File: rtl/mult_share_ctrl.sv
// rtl/mult_share_ctrl.sv - two-requester arbiter and sequencer for a shared signed shift-add multiplier
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   req0_i, req1_i       operation requests (held with stable operands until ack)
//   a0_i, b0_i           requester 0 multiplicand / multiplier (signed)
//   a1_i, b1_i           requester 1 multiplicand / multiplier (signed)
//   ack0_o, ack1_o       one-cycle pulse: operands of that requester captured
//   done0_o, done1_o     one-cycle pulse: product_o valid for that requester
//   product_o            signed 2*WIDTH product, held until the next done
//   busy_o               high from grant until the result is delivered
//   owner_o              requester owning the current/last operation
module mult_share_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               req0_i,
    input  logic               req1_i,
    input  logic [WIDTH-1:0]   a0_i,
    input  logic [WIDTH-1:0]   b0_i,
    input  logic [WIDTH-1:0]   a1_i,
    input  logic [WIDTH-1:0]   b1_i,
    output logic               ack0_o,
    output logic               ack1_o,
    output logic               done0_o,
    output logic               done1_o,
    output logic [2*WIDTH-1:0] product_o,
    output logic               busy_o,
    output logic               owner_o
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_RUN    = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    state_t           state_q;
    logic [PW-1:0]    mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [PW-1:0]    acc_q;
    logic [CW-1:0]    iter_q;
    logic             sign_q;
    logic             last_q;

    logic             gnt_idx_d;
    logic [WIDTH-1:0] sel_a_d;
    logic [WIDTH-1:0] sel_b_d;
    logic [WIDTH-1:0] a_mag_d;
    logic [WIDTH-1:0] b_mag_d;
    logic [WIDTH-1:0] mplier_d;
    logic [PW-1:0]    acc_d;
    logic [PW-1:0]    product_d;

    always_comb begin
        // On a tie the requester that did not win last time gets the grant.
        gnt_idx_d = (req0_i && req1_i) ? ~last_q : req1_i;
        sel_a_d   = gnt_idx_d ? a1_i : a0_i;
        sel_b_d   = gnt_idx_d ? b1_i : b0_i;
        // Unsigned magnitude: the most negative value maps to 2^(WIDTH-1) naturally.
        a_mag_d   = sel_a_d[WIDTH-1] ? (-sel_a_d) : sel_a_d;
        b_mag_d   = sel_b_d[WIDTH-1] ? (-sel_b_d) : sel_b_d;
        mplier_d  = mplier_q >> 1;
        acc_d     = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        product_d = sign_q ? (-acc_q) : acc_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            iter_q    <= '0;
            sign_q    <= 1'b0;
            last_q    <= 1'b1;
            ack0_o    <= 1'b0;
            ack1_o    <= 1'b0;
            done0_o   <= 1'b0;
            done1_o   <= 1'b0;
            product_o <= '0;
            busy_o    <= 1'b0;
            owner_o   <= 1'b0;
        end else begin
            ack0_o  <= 1'b0;
            ack1_o  <= 1'b0;
            done0_o <= 1'b0;
            done1_o <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req0_i || req1_i) begin
                        state_q  <= ST_LOAD;
                        busy_o   <= 1'b1;
                        owner_o  <= gnt_idx_d;
                        last_q   <= gnt_idx_d;
                        mcand_q  <= {{WIDTH{1'b0}}, a_mag_d};
                        mplier_q <= b_mag_d;
                        sign_q   <= sel_a_d[WIDTH-1] ^ sel_b_d[WIDTH-1];
                        acc_q    <= '0;
                        iter_q   <= '0;
                        ack0_o   <= ~gnt_idx_d;
                        ack1_o   <= gnt_idx_d;
                    end
                end
                ST_LOAD: begin
                    state_q <= (mplier_q != '0) ? ST_RUN : ST_FINISH;
                end
                ST_RUN: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_d;
                    iter_q   <= iter_q + CW'(1);
                    // Early exit once no set multiplier bits remain; the counter
                    // bounds the loop at WIDTH iterations regardless.
                    if ((mplier_d == '0) || (iter_q == CW'(WIDTH - 1))) begin
                        state_q <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    product_o <= product_d;
                    done0_o   <= ~owner_o;
                    done1_o   <= owner_o;
                    busy_o    <= 1'b0;
                    state_q   <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_share_ctrl.sv
// tb/tb_mult_share_ctrl.sv - self-checking bench for mult_share_ctrl
module tb_mult_share_ctrl;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        req0, req1;
    logic [7:0]  a0, b0, a1, b1;
    logic        ack0, ack1, done0, done1, busy, owner;
    logic [15:0] product;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    always #5 clk = ~clk;

    mult_share_ctrl #(.WIDTH(8)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_ni),
        .req0_i    (req0),
        .req1_i    (req1),
        .a0_i      (a0),
        .b0_i      (b0),
        .a1_i      (a1),
        .b1_i      (b1),
        .ack0_o    (ack0),
        .ack1_o    (ack1),
        .done0_o   (done0),
        .done1_o   (done1),
        .product_o (product),
        .busy_o    (busy),
        .owner_o   (owner)
    );

    typedef struct {
        bit          sel;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] ep;
        int          k;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    endtask

    function automatic logic [15:0] model_prod(input logic [7:0] a, input logic [7:0] b);
        int av;
        int bv;
        av = $signed(a);
        bv = $signed(b);
        return 16'(av * bv);
    endfunction

    function automatic int model_k(input logic [7:0] b);
        int m;
        int k;
        m = $signed(b);
        if (m < 0) m = -m;
        k = 0;
        while (m > 0) begin
            k++;
            m = m >> 1;
        end
        return k;
    endfunction

    task automatic set_ops(input bit sel, input logic [7:0] a, input logic [7:0] b);
        if (sel) begin a1 = a; b1 = b; end
        else begin a0 = a; b0 = b; end
    endtask

    task automatic set_req(input bit sel, input logic v);
        if (sel) req1 = v;
        else req0 = v;
    endtask

    task automatic wait_ack(input bit sel, input string nm);
        int n;
        n = 0;
        while (!(ack0 || ack1) && n < 20) begin
            tick();
            n++;
        end
        chk({nm, "_ack_sel"}, {30'd0, ack1, ack0}, sel ? 32'd2 : 32'd1);
        chk({nm, "_busy_at_ack"}, {31'd0, busy}, 32'd1);
        chk({nm, "_owner"}, {31'd0, owner}, {31'd0, sel});
        set_req(sel, 1'b0);
    endtask

    task automatic wait_done(input bit sel, input logic [15:0] ep, input int k, input string nm);
        int c;
        bit stray;
        c = 0;
        stray = 1'b0;
        while (c < 40) begin
            tick();
            c++;
            if (done0 || done1) break;
            if (ack0 || ack1 || !busy) stray = 1'b1;
        end
        chk({nm, "_latency"}, c, k + 2);
        chk({nm, "_done_sel"}, {30'd0, done1, done0}, sel ? 32'd2 : 32'd1);
        chk({nm, "_product"}, {16'd0, product}, {16'd0, ep});
        chk({nm, "_busy_low"}, {31'd0, busy}, 32'd0);
        chk({nm, "_no_stray"}, {31'd0, stray}, 32'd0);
        tick();
        chk({nm, "_done_pulse"}, {16'd0, done1, done0, product}, {16'd0, 2'b00, ep});
    endtask

    task automatic run_op(input bit sel, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] ep, input int k, input string nm);
        set_ops(sel, a, b);
        set_req(sel, 1'b1);
        wait_ack(sel, nm);
        wait_done(sel, ep, k, nm);
    endtask

    vec_t vecs[7];

    initial begin
        bit stray;
        vecs[0] = '{sel: 1'b0, a: 8'h05, b: 8'h03, ep: 16'h000F, k: 2};
        vecs[1] = '{sel: 1'b1, a: 8'hF9, b: 8'h06, ep: 16'hFFD6, k: 3};
        vecs[2] = '{sel: 1'b0, a: 8'h80, b: 8'h80, ep: 16'h4000, k: 8};
        vecs[3] = '{sel: 1'b1, a: 8'h12, b: 8'h00, ep: 16'h0000, k: 0};
        vecs[4] = '{sel: 1'b0, a: 8'h80, b: 8'h01, ep: 16'hFF80, k: 1};
        vecs[5] = '{sel: 1'b1, a: 8'hFF, b: 8'h00, ep: 16'h0000, k: 0};
        vecs[6] = '{sel: 1'b0, a: 8'hFD, b: 8'hFE, ep: 16'h0006, k: 2};

        rst_ni = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        a0 = 8'd0; b0 = 8'd0; a1 = 8'd0; b1 = 8'd0;
        tick();
        tick();
        chk("reset_outputs", {10'd0, ack0, ack1, done0, done1, busy, owner, product}, 32'd0);

        // Tie from reset: req0 wins first, then req1, then req0 again.
        set_ops(0, 8'h03, 8'h04);
        set_ops(1, 8'hFB, 8'h07);
        req0 = 1'b1; req1 = 1'b1;
        rst_ni = 1'b1;
        wait_ack(0, "tie1");
        wait_done(0, 16'h000C, 3, "tie1");
        wait_ack(1, "tie2");
        wait_done(1, 16'hFFDD, 3, "tie2");
        set_ops(0, 8'h06, 8'hFF);
        set_ops(1, 8'h02, 8'h02);
        req0 = 1'b1; req1 = 1'b1;
        wait_ack(0, "tie3");
        wait_done(0, 16'hFFFA, 1, "tie3");
        wait_ack(1, "tie4");
        wait_done(1, 16'h0004, 2, "tie4");

        foreach (vecs[i]) begin
            run_op(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].ep, vecs[i].k, $sformatf("vec%0d", i));
        end

        // Reset in the middle of RUN discards the operation.
        set_ops(0, 8'h80, 8'h80);
        req0 = 1'b1;
        wait_ack(0, "rst_op");
        tick();
        tick();
        tick();
        rst_ni = 1'b0;
        #1;
        chk("midrun_reset_outputs", {10'd0, ack0, ack1, done0, done1, busy, owner, product}, 32'd0);
        tick();
        tick();
        rst_ni = 1'b1;
        stray = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done0 || done1 || ack0 || ack1 || busy) stray = 1'b1;
        end
        chk("no_done_after_reset", {31'd0, stray}, 32'd0);
        run_op(0, 8'h02, 8'h02, 16'h0004, 2, "post_reset");

        for (int i = 0; i < 40; i++) begin
            bit          sel;
            logic [7:0]  a;
            logic [7:0]  b;
            sel = 1'($urandom_range(0, 1));
            a   = 8'($urandom);
            b   = 8'($urandom);
            run_op(sel, a, b, model_prod(a, b), model_k(b), $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
